alu_result_serializer: RTL

//  Downstream of the multiplier stage. Captures one 32-bit result word plus its

---
 rtl/alu_result_serializer_pkg.sv | 22 ++
 rtl/alu_result_serializer_timer.sv | 31 +++
 rtl/alu_result_serializer.sv | 98 +++++++++
 3 files changed

// File: rtl/alu_result_serializer_pkg.sv
// Shared types and constants for the ALU result serializer.
`timescale 1ns/1ps
package alu_pkg;

    localparam int   DEF_DATA_W = 32;
    localparam int   FRAME_BITS = DEF_DATA_W + 3;
    localparam logic TX_IDLE    = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        FLAG,
        STOP
    } state_e;

    // Counter width for a terminal count of n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alu_result_serializer_timer.sv
// Bit-period timer: bit_end marks the last clk cycle of each serial bit.
`timescale 1ns/1ps
module alu_bit_timer
    import alu_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic bit_end
);

    localparam int            CW   = cnt_w(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (clear)
            r_cnt <= '0;
        else if (en)
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end

    assign bit_end = en && (r_cnt == LAST);

endmodule

// File: rtl/alu_result_serializer.sv
// Captures one result word + balance flag and sends start/data/flag/stop LSB-first on tx.
`timescale 1ns/1ps
module alu_result_serializer
    import alu_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic              in_balance,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int            IW       = cnt_w(DATA_W);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

    state_e            r_state, w_state_nxt;
    logic [DATA_W-1:0] r_shreg, w_shreg_nxt;
    logic              r_flag,  w_flag_nxt;
    logic [IW-1:0]     r_idx,   w_idx_nxt;
    logic              r_tx,    w_tx_nxt;
    logic              r_busy;
    logic              w_bit_end;

    // Timer is held at zero while idle so START always gets a full bit period.
    alu_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (r_state == IDLE),
        .en      (r_state != IDLE),
        .bit_end (w_bit_end)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_flag_nxt  = r_flag;
        w_idx_nxt   = r_idx;
        case (r_state)
            IDLE: if (in_valid) begin
                w_state_nxt = START;
                w_shreg_nxt = in_result;
                w_flag_nxt  = in_balance;
                w_idx_nxt   = '0;
            end
            START: if (w_bit_end) w_state_nxt = DATA;
            DATA: if (w_bit_end) begin
                w_shreg_nxt = r_shreg >> 1;
                if (r_idx == LAST_IDX) w_state_nxt = FLAG;
                else                   w_idx_nxt   = r_idx + 1'b1;
            end
            FLAG: if (w_bit_end) w_state_nxt = STOP;
            STOP: if (w_bit_end) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // tx is computed from next-cycle state so the line is a clean flop output.
    always_comb begin
        w_tx_nxt = TX_IDLE;
        case (w_state_nxt)
            START:   w_tx_nxt = 1'b0;
            DATA:    w_tx_nxt = w_shreg_nxt[0];
            FLAG:    w_tx_nxt = w_flag_nxt;
            default: w_tx_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_shreg <= '0;
            r_flag  <= 1'b0;
            r_idx   <= '0;
            r_tx    <= TX_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shreg <= w_shreg_nxt;
            r_flag  <= w_flag_nxt;
            r_idx   <= w_idx_nxt;
            r_tx    <= w_tx_nxt;
            r_busy  <= (w_state_nxt != IDLE);
        end
    end

    assign in_ready = (r_state == IDLE);
    assign tx       = r_tx;
    assign busy     = r_busy;
    assign done     = (r_state == STOP) && w_bit_end;

endmodule
